ahb_lite_sram_slave: RTL and testbench

AHB-Lite responder backed by a small register-array memory. It is the target end of the bus that the DMA channel master drives, and is used as the on-chip scratch buffer and as the bench target for the DMA master. It supports byte, halfword and word transfers with per-lane writes, a programmable number of wait states, and a two-cycle ERROR response for illegal accesses. Pipelined back-to-back transfers are supported.

---
 rtl/ahb_lite_pkg.sv | 30 +++
 rtl/ahb_lite_sram_slave.sv | 137 +++++++++++++
 tb/tb_ahb_lite_sram_slave.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings and lane-mask helper used by both bus masters and responders.
// Pure definitions: no state, no latency, no flow control of its own.
package ahb_lite;

  localparam logic [1:0] AHB_IDLE   = 2'b00;
  localparam logic [1:0] AHB_BUSY   = 2'b01;
  localparam logic [1:0] AHB_NONSEQ = 2'b10;
  localparam logic [1:0] AHB_SEQ    = 2'b11;

  localparam logic AHB_OKAY  = 1'b0;
  localparam logic AHB_ERROR = 1'b1;

  localparam logic [2:0] AHB_BYTE = 3'b000;
  localparam logic [2:0] AHB_HALF = 3'b001;
  localparam logic [2:0] AHB_WORD = 3'b010;

  // Byte-lane enables of a 32-bit bus for a transfer of the given size at addr[1:0].
  function automatic logic [3:0] ahb_lane_mask(input logic [2:0] size, input logic [1:0] addr);
    logic [3:0] mask;
    mask = 4'b0000;
    case (size)
      AHB_BYTE: mask = 4'b0001 << addr;
      AHB_HALF: mask = addr[1] ? 4'b1100 : 4'b0011;
      AHB_WORD: mask = 4'b1111;
      default:  mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite responder over a register-array memory; OKAY data phase takes WAIT_STATES+1 cycles, ERROR takes 2.
// Stalls the master by dropping s_hreadyout_o; back-to-back address phases chain without a bubble.
module ahb_lite_sram_slave
  import ahb_lite::*;
#(
  parameter int AHB_ADDR_SIZE = 32,
  parameter int AHB_DATA_SIZE = 32,
  parameter int MEM_WORDS     = 16,
  parameter int WAIT_STATES   = 0
) (
  input  logic                     hclk,
  input  logic                     hreset,
  input  logic                     s_hsel_i,
  input  logic [AHB_ADDR_SIZE-1:0] s_haddr_i,
  input  logic [AHB_DATA_SIZE-1:0] s_hwdata_i,
  output logic [AHB_DATA_SIZE-1:0] s_hrdata_o,
  input  logic                     s_hwrite_i,
  input  logic [2:0]               s_hsize_i,
  input  logic [2:0]               s_hburst_i,
  input  logic [3:0]               s_hprot_i,
  input  logic [1:0]               s_htrans_i,
  input  logic                     s_hmastlock_i,
  input  logic                     s_hready_i,
  output logic                     s_hreadyout_o,
  output logic                     s_hresp_o
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int LO_W  = IDX_W + 2;
  localparam logic [2:0] WS_LAST = 3'(WAIT_STATES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_OKAY_LAST,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [LO_W-1:0] addr_q;
  logic [2:0] size_q;
  logic write_q;
  logic launch;
  logic accept;
  logic legal;
  logic aligned;
  logic [3:0] mask;
  logic [IDX_W-1:0] idx;
  logic [AHB_DATA_SIZE-1:0] mem [MEM_WORDS];

  logic unused_ok;
  assign unused_ok = ^{s_hburst_i, s_hprot_i, s_hmastlock_i, s_htrans_i[0]};

  assign accept = s_hsel_i & s_htrans_i[1] & s_hready_i;

  always_comb begin
    aligned = 1'b1;
    case (s_hsize_i)
      AHB_HALF: aligned = ~s_haddr_i[0];
      AHB_WORD: aligned = (s_haddr_i[1:0] == 2'b00);
      default:  aligned = 1'b1;
    endcase
  end

  assign legal = (s_hsize_i <= AHB_WORD) & aligned &
                 (s_haddr_i < AHB_ADDR_SIZE'(4 * MEM_WORDS));

  // IDLE, OKAY_LAST and ERR2 all present hreadyout high, so each can take a new address phase.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    launch  = 1'b0;
    case (state_q)
      ST_IDLE, ST_OKAY_LAST, ST_ERR2: begin
        state_d = ST_IDLE;
        cnt_d   = 3'd0;
        if (accept) begin
          launch = 1'b1;
          if (!legal)
            state_d = ST_ERR1;
          else if (WAIT_STATES == 0)
            state_d = ST_OKAY_LAST;
          else
            state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt_q == WS_LAST) begin
          state_d = ST_OKAY_LAST;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      addr_q  <= '0;
      size_q  <= AHB_BYTE;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (launch) begin
        addr_q  <= s_haddr_i[LO_W-1:0];
        size_q  <= s_hsize_i;
        write_q <= s_hwrite_i;
      end
    end
  end

  assign mask = ahb_lane_mask(size_q, addr_q[1:0]);
  assign idx  = addr_q[LO_W-1:2];

  // Reset forces state_q out of OKAY_LAST asynchronously, so a pending write never reaches this edge.
  always_ff @(posedge hclk) begin
    if (state_q == ST_OKAY_LAST && write_q) begin
      for (int b = 0; b < 4; b++) begin
        if (mask[b])
          mem[idx][8*b +: 8] <= s_hwdata_i[8*b +: 8];
      end
    end
  end

  assign s_hreadyout_o = (state_q != ST_DATA) && (state_q != ST_ERR1);
  assign s_hresp_o     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? AHB_ERROR : AHB_OKAY;
  assign s_hrdata_o    = (state_q == ST_OKAY_LAST) ? mem[idx] : '0;

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Directed bench: three responders (0, 3 and 2 wait states) share one bus driven by a simple master model.
// Each transfer targets one responder through its own hsel; expected values are hand-computed constants.
module tb_ahb_lite_sram_slave;

  logic        hclk;
  logic        hreset;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [1:0]  htrans;
  logic        rdy_block;
  logic        hsel_w   [3];
  logic [31:0] hrdata_w [3];
  logic        hrdyo_w  [3];
  logic        hresp_w  [3];
  logic        hready_w [3];

  int n_chk = 0;
  int n_bad = 0;

  for (genvar g = 0; g < 3; g++) begin : g_rdy
    assign hready_w[g] = hrdyo_w[g] & ~rdy_block;
  end

  ahb_lite_sram_slave #(.WAIT_STATES(0)) u_ws0 (
    .hclk(hclk), .hreset(hreset), .s_hsel_i(hsel_w[0]), .s_haddr_i(haddr),
    .s_hwdata_i(hwdata), .s_hrdata_o(hrdata_w[0]), .s_hwrite_i(hwrite), .s_hsize_i(hsize),
    .s_hburst_i(3'b000), .s_hprot_i(4'b0011), .s_htrans_i(htrans), .s_hmastlock_i(1'b0),
    .s_hready_i(hready_w[0]), .s_hreadyout_o(hrdyo_w[0]), .s_hresp_o(hresp_w[0]));

  ahb_lite_sram_slave #(.WAIT_STATES(3)) u_ws3 (
    .hclk(hclk), .hreset(hreset), .s_hsel_i(hsel_w[1]), .s_haddr_i(haddr),
    .s_hwdata_i(hwdata), .s_hrdata_o(hrdata_w[1]), .s_hwrite_i(hwrite), .s_hsize_i(hsize),
    .s_hburst_i(3'b000), .s_hprot_i(4'b0011), .s_htrans_i(htrans), .s_hmastlock_i(1'b0),
    .s_hready_i(hready_w[1]), .s_hreadyout_o(hrdyo_w[1]), .s_hresp_o(hresp_w[1]));

  ahb_lite_sram_slave #(.WAIT_STATES(2)) u_ws2 (
    .hclk(hclk), .hreset(hreset), .s_hsel_i(hsel_w[2]), .s_haddr_i(haddr),
    .s_hwdata_i(hwdata), .s_hrdata_o(hrdata_w[2]), .s_hwrite_i(hwrite), .s_hsize_i(hsize),
    .s_hburst_i(3'b000), .s_hprot_i(4'b0011), .s_htrans_i(htrans), .s_hmastlock_i(1'b0),
    .s_hready_i(hready_w[2]), .s_hreadyout_o(hrdyo_w[2]), .s_hresp_o(hresp_w[2]));

  initial begin
    hclk = 1'b0;
    forever #5 hclk = ~hclk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // One isolated transfer to responder d: address phase, then data phase until hreadyout rises.
  task automatic do_xfer(input int d, input logic wr, input logic [31:0] addr,
                         input logic [2:0] size, input logic [31:0] wdata,
                         output logic [31:0] rdata, output int lows, output logic resp,
                         output logic resp_lo);
    @(posedge hclk); #1;
    hsel_w[d] = 1'b1; htrans = 2'b10; haddr = addr; hwrite = wr; hsize = size;
    @(posedge hclk); #1;
    hsel_w[d] = 1'b0; htrans = 2'b00; hwdata = wdata;
    lows = 0;
    resp_lo = 1'b0;
    #2;
    while (!hrdyo_w[d] && lows < 20) begin
      if (lows == 0) resp_lo = hresp_w[d];
      lows++;
      @(posedge hclk); #3;
    end
    rdata = hrdata_w[d];
    resp  = hresp_w[d];
  endtask

  logic [31:0] rd;
  int          lw;
  logic        rs, rl;

  initial begin
    hreset = 1'b1; haddr = '0; hwdata = '0; hwrite = 1'b0; hsize = 3'd0;
    htrans = 2'b00; rdy_block = 1'b0;
    for (int i = 0; i < 3; i++) hsel_w[i] = 1'b0;
    #23;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_rdy%0d", i), 32'(hrdyo_w[i]), 32'd1);
      chk($sformatf("rst_resp%0d", i), 32'(hresp_w[i]), 32'd0);
      chk($sformatf("rst_rdata%0d", i), hrdata_w[i], 32'd0);
    end
    @(negedge hclk); hreset = 1'b0;

    // 1: back-to-back word write then read, zero wait states
    @(posedge hclk); #1;
    hsel_w[0] = 1'b1; htrans = 2'b10; haddr = 32'h4; hwrite = 1'b1; hsize = 3'd2;
    #2 chk("t1_rdy_addr", 32'(hrdyo_w[0]), 32'd1);
    @(posedge hclk); #1;
    hwdata = 32'hDEADBEEF; hwrite = 1'b0;
    #2 chk("t1_rdy_wr", 32'(hrdyo_w[0]), 32'd1);
    @(posedge hclk); #1;
    hsel_w[0] = 1'b0; htrans = 2'b00; hwdata = 32'h0;
    #2 chk("t1_rdy_rd", 32'(hrdyo_w[0]), 32'd1);
    chk("t1_rdata", hrdata_w[0], 32'hDEADBEEF);
    chk("t1_resp", 32'(hresp_w[0]), 32'd0);

    // 2: byte and halfword lane writes
    do_xfer(0, 1'b1, 32'h8, 3'd2, 32'h11223344, rd, lw, rs, rl);
    do_xfer(0, 1'b1, 32'h9, 3'd0, 32'hFFFFAAFF, rd, lw, rs, rl);
    do_xfer(0, 1'b0, 32'h8, 3'd2, 32'h0, rd, lw, rs, rl);
    chk("t2_byte", rd, 32'h1122AA44);
    do_xfer(0, 1'b1, 32'hA, 3'd1, 32'hBEEF7777, rd, lw, rs, rl);
    do_xfer(0, 1'b0, 32'h8, 3'd2, 32'h0, rd, lw, rs, rl);
    chk("t2_half", rd, 32'hBEEFAA44);

    // 3: three wait states on a halfword read
    do_xfer(1, 1'b1, 32'h0, 3'd2, 32'hCAFE1234, rd, lw, rs, rl);
    chk("t3_wr_waits", 32'(lw), 32'd3);
    do_xfer(1, 1'b0, 32'h2, 3'd1, 32'h0, rd, lw, rs, rl);
    chk("t3_waits", 32'(lw), 32'd3);
    chk("t3_rdata", rd, 32'hCAFE1234);
    chk("t3_resp", 32'(rs), 32'd0);

    // 4: out-of-range and misaligned accesses answer ERROR and leave word 0 intact
    do_xfer(0, 1'b1, 32'h0, 3'd2, 32'h01020304, rd, lw, rs, rl);
    do_xfer(0, 1'b1, 32'h40, 3'd2, 32'h55555555, rd, lw, rs, rl);
    chk("t4_oor_lows", 32'(lw), 32'd1);
    chk("t4_oor_err1", 32'(rl), 32'd1);
    chk("t4_oor_err2", 32'(rs), 32'd1);
    do_xfer(0, 1'b1, 32'h1, 3'd1, 32'hFFFFFFFF, rd, lw, rs, rl);
    chk("t4_mis_lows", 32'(lw), 32'd1);
    chk("t4_mis_err1", 32'(rl), 32'd1);
    chk("t4_mis_err2", 32'(rs), 32'd1);
    do_xfer(0, 1'b0, 32'h0, 3'd2, 32'h0, rd, lw, rs, rl);
    chk("t4_mem", rd, 32'h01020304);
    chk("t4_okay", 32'(rs), 32'd0);

    // 5: NONSEQ while hready is low, then IDLE: nothing launches
    do_xfer(0, 1'b1, 32'hC, 3'd2, 32'h0BADF00D, rd, lw, rs, rl);
    @(posedge hclk); #1;
    hsel_w[0] = 1'b1; htrans = 2'b10; haddr = 32'hC; hwrite = 1'b1; hsize = 3'd2;
    rdy_block = 1'b1;
    @(posedge hclk); #1;
    rdy_block = 1'b0; htrans = 2'b00; hwdata = 32'hFFFFFFFF;
    #2 chk("t5_rdy", 32'(hrdyo_w[0]), 32'd1);
    chk("t5_resp", 32'(hresp_w[0]), 32'd0);
    chk("t5_rdata", hrdata_w[0], 32'd0);
    @(posedge hclk); #1;
    hsel_w[0] = 1'b0;
    #2 chk("t5_rdy2", 32'(hrdyo_w[0]), 32'd1);
    do_xfer(0, 1'b0, 32'hC, 3'd2, 32'h0, rd, lw, rs, rl);
    chk("t5_mem", rd, 32'h0BADF00D);

    // 6: reset during the wait states of a write discards it
    do_xfer(2, 1'b1, 32'h14, 3'd2, 32'h13579BDF, rd, lw, rs, rl);
    chk("t6_wr_waits", 32'(lw), 32'd2);
    @(posedge hclk); #1;
    hsel_w[2] = 1'b1; htrans = 2'b10; haddr = 32'h14; hwrite = 1'b1; hsize = 3'd2;
    @(posedge hclk); #1;
    hsel_w[2] = 1'b0; htrans = 2'b00; hwdata = 32'hFFFFFFFF;
    #2 chk("t6_rdy_data", 32'(hrdyo_w[2]), 32'd0);
    #1 hreset = 1'b1;
    #1 chk("t6_rst_rdy", 32'(hrdyo_w[2]), 32'd1);
    chk("t6_rst_resp", 32'(hresp_w[2]), 32'd0);
    chk("t6_rst_rdata", hrdata_w[2], 32'd0);
    repeat (2) @(posedge hclk);
    @(negedge hclk); hreset = 1'b0;
    do_xfer(2, 1'b0, 32'h14, 3'd2, 32'h0, rd, lw, rs, rl);
    chk("t6_mem", rd, 32'h13579BDF);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
